key_press_ctrl: RTL and testbench

- Downstream consumer of the button debouncer in the FND sequencer path.
- Takes the debounced key level and classifies it into single-cycle event pulses: press, short release, long press and auto-repeat.
- The FND sequence/counter logic uses these pulses to step, reset or fast-advance the display without doing any timing of its own.

---
 rtl/key_pkg.sv | 21 ++
 rtl/key_press_ctrl_if.sv | 30 +++
 rtl/key_hold_timer.sv | 36 +++
 rtl/key_press_ctrl.sv | 124 ++++++++++++
 tb/tb_key_press_ctrl.sv | 130 +++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key press classifier.
// Defaults assume a 50 MHz clock; SIM_* are short values for simulation.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LONG = 2'd2
  } state_e;

  localparam int LONG_CYCLES_DEF   = 50_000_000;
  localparam int REPEAT_CYCLES_DEF = 10_000_000;

  localparam int SIM_LONG_CYCLES   = 8;
  localparam int SIM_REPEAT_CYCLES = 4;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_press_ctrl_if.sv
// Key level in, classified event pulses out.
// slave = classifier side, master = key source / consumer side.
interface key_press_ctrl_if;

  logic data_in;
  logic key_held;
  logic press_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;

  modport master (
    output data_in,
    input  key_held,
    input  press_pulse,
    input  short_pulse,
    input  long_pulse,
    input  repeat_pulse
  );

  modport slave (
    input  data_in,
    output key_held,
    output press_pulse,
    output short_pulse,
    output long_pulse,
    output repeat_pulse
  );

endinterface

// File: rtl/key_hold_timer.sv
// Hold-time counter with sync clear, enable and terminal compare.
// hit is combinational so the FSM can act on the terminal this cycle.
module key_hold_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == term);

endmodule

// File: rtl/key_press_ctrl.sv
// Classifies a debounced key level into press, short,
// long and auto-repeat single-cycle pulses.
module key_press_ctrl
  import key_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int REPEAT_EN     = 1
) (
  input logic             clk,
  input logic             reset_n,
  key_press_ctrl_if.slave kif
);

  localparam int CNT_W =
    $clog2(max_i(LONG_CYCLES, REPEAT_CYCLES));

  localparam logic [CNT_W-1:0] LONG_TERM =
    CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_TERM =
    CNT_W'(REPEAT_CYCLES - 1);
  localparam logic RPT_ON = (REPEAT_EN != 0);

  state_e state_q, state_d;
  logic   key_q, key_d;
  logic   press_q, press_d;
  logic   short_q, short_d;
  logic   long_q, long_d;
  logic   rpt_q, rpt_d;

  logic             rise, fall;
  logic             clr, en, hit;
  logic [CNT_W-1:0] term;

  assign rise = kif.data_in & ~key_q;
  assign fall = ~kif.data_in & key_q;

  assign term = (state_q == LONG) ? RPT_TERM : LONG_TERM;

  key_hold_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .en      (en),
    .term    (term),
    .hit     (hit)
  );

  // Release is checked before the terminal so it always wins.
  always_comb begin
    state_d = state_q;
    key_d   = kif.data_in;
    clr     = 1'b0;
    en      = 1'b0;
    press_d = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (rise) begin
          state_d = HOLD;
          press_d = 1'b1;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d = IDLE;
          clr     = 1'b1;
          short_d = 1'b1;
        end else if (hit) begin
          state_d = LONG;
          clr     = 1'b1;
          long_d  = 1'b1;
        end else begin
          en = 1'b1;
        end
      end
      LONG: begin
        if (fall) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else if (hit) begin
          clr   = 1'b1;
          rpt_d = RPT_ON;
        end else begin
          en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        clr     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      key_q   <= 1'b0;
      press_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      press_q <= press_d;
      short_q <= short_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
    end
  end

  assign kif.key_held     = key_q;
  assign kif.press_pulse  = press_q;
  assign kif.short_pulse  = short_q;
  assign kif.long_pulse   = long_q;
  assign kif.repeat_pulse = rpt_q;

endmodule

// File: tb/tb_key_press_ctrl.sv
// Directed bench for key_press_ctrl with LONG=8, REPEAT=4.
// Output vector order: {held, press, short, long, repeat}.
module tb_key_press_ctrl;
  import key_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  key_press_ctrl_if kif0 ();
  key_press_ctrl_if kif1 ();

  assign kif1.data_in = kif0.data_in;

  key_press_ctrl #(
    .LONG_CYCLES   (SIM_LONG_CYCLES),
    .REPEAT_CYCLES (SIM_REPEAT_CYCLES),
    .REPEAT_EN     (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kif     (kif0.slave)
  );

  key_press_ctrl #(
    .LONG_CYCLES   (SIM_LONG_CYCLES),
    .REPEAT_CYCLES (SIM_REPEAT_CYCLES),
    .REPEAT_EN     (0)
  ) dut_norpt (
    .clk     (clk),
    .reset_n (reset_n),
    .kif     (kif1.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs0();
    return {kif0.key_held, kif0.press_pulse,
            kif0.short_pulse, kif0.long_pulse,
            kif0.repeat_pulse};
  endfunction

  function automatic logic [4:0] obs1();
    return {kif1.key_held, kif1.press_pulse,
            kif1.short_pulse, kif1.long_pulse,
            kif1.repeat_pulse};
  endfunction

  task automatic chk(input string tag,
                     input logic [4:0] o,
                     input logic [4:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %b exp %b", tag, o, e);
    end
  endtask

  // Drive data_in, clock one edge, check DUT0 just after the edge.
  task automatic cyc(input logic d,
                     input logic [4:0] e,
                     input string tag);
    kif0.data_in = d;
    @(posedge clk);
    #1;
    chk(tag, obs0(), e);
  endtask

  initial begin
    reset_n      = 1'b0;
    kif0.data_in = 1'b1;

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 5'b00000, "reset_hold");
    end
    reset_n = 1'b1;
    cyc(1'b1, 5'b11000, "post_reset_press");

    for (int i = 2; i <= 5; i++) begin
      cyc(1'b1, 5'b10000, "short_hold");
    end
    cyc(1'b0, 5'b00100, "short_pulse");
    cyc(1'b0, 5'b00000, "short_after");
    cyc(1'b0, 5'b00000, "idle");

    for (int i = 1; i <= 20; i++) begin
      logic [4:0] e0;
      logic [4:0] e1;
      e0 = {1'b1, (i == 1), 1'b0, (i == 9),
            (i > 9) && ((i - 9) % 4 == 0)};
      e1 = {1'b1, (i == 1), 1'b0, (i == 9), 1'b0};
      cyc(1'b1, e0, "long_rpt");
      chk("norpt_hold", obs1(), e1);
    end
    cyc(1'b0, 5'b00000, "long_release");
    chk("norpt_release", obs1(), 5'b00000);
    cyc(1'b0, 5'b00000, "long_release_idle");

    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, (i == 1) ? 5'b11000 : 5'b10000, "bnd_short_hold");
    end
    cyc(1'b0, 5'b00100, "bnd_short_pulse");
    cyc(1'b0, 5'b00000, "bnd_short_idle");

    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, (i == 1) ? 5'b11000 : 5'b10000, "bnd_long_hold");
    end
    cyc(1'b1, 5'b10010, "bnd_long_pulse");
    cyc(1'b0, 5'b00000, "bnd_long_release");
    cyc(1'b0, 5'b00000, "bnd_long_idle");

    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, (i == 1) ? 5'b11000 : 5'b10000, "mid_hold");
    end
    reset_n = 1'b0;
    cyc(1'b1, 5'b00000, "mid_reset");
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 5'b00000, "mid_after_reset");
    end
    cyc(1'b1, 5'b11000, "fresh_press");
    cyc(1'b0, 5'b00100, "fresh_short");
    cyc(1'b0, 5'b00000, "fresh_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
